// File: rtl/mm2017_run_ctrl_if.sv
// Handshake/status bundle between the MM2017 run controller and its host/core side.
// Trace signals exist only when MM_RUN_TRACE_EN is defined.
interface mm2017_run_ctrl_if #(
    parameter int PC_W        = 64,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16
);
    logic              start;
    logic [PC_W-1:0]   halt_addr;
    logic              halt_addr_en;
    logic [PC_W-1:0]   pc_in;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycles;
    logic [PC_W-1:0]   last_pc;
`ifdef MM_RUN_TRACE_EN
    localparam int TI_W = $clog2(TRACE_DEPTH);
    logic [TI_W-1:0]   trace_idx;
    logic [PC_W-1:0]   trace_pc;

    modport master (
        output start, halt_addr, halt_addr_en, pc_in, trace_idx,
        input  core_rst, running, done, timeout, cycles, last_pc, trace_pc
    );
    modport slave (
        input  start, halt_addr, halt_addr_en, pc_in, trace_idx,
        output core_rst, running, done, timeout, cycles, last_pc, trace_pc
    );
`else
    modport master (
        output start, halt_addr, halt_addr_en, pc_in,
        input  core_rst, running, done, timeout, cycles, last_pc
    );
    modport slave (
        input  start, halt_addr, halt_addr_en, pc_in,
        output core_rst, running, done, timeout, cycles, last_pc
    );
`endif
endinterface

// File: rtl/mm2017_run_ctrl.sv
// MM2017 run controller: holds core reset, runs the core, stops on halt address, PC stall or budget.
// Optional PC trace buffer enabled by defining MM_RUN_TRACE_EN.
module mm2017_run_ctrl #(
    parameter int PC_W        = 64,
    parameter int CNT_W       = 32,
    parameter int RST_HOLD    = 4,
    parameter int HALT_STABLE = 8,
    parameter int MAX_CYCLES  = 1000,
    parameter int TRACE_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    mm2017_run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    localparam int HOLD_W  = $clog2(RST_HOLD + 1);
    localparam int STALL_W = $clog2(HALT_STABLE + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(HALT_STABLE - 1);
    localparam logic [CNT_W-1:0]   CYC_LIM   = CNT_W'(MAX_CYCLES - 1);
    localparam bit                 TO_EN     = (MAX_CYCLES != 0);

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [STALL_W-1:0]  r_stall;
    logic [CNT_W-1:0]    r_cycles;
    logic [PC_W-1:0]     r_last_pc;
    logic                r_core_rst;
    logic                r_running;
    logic                r_done;
    logic                r_timeout;

    state_t              w_next;
    logic                w_start_ok;
    logic                w_first;
    logic                w_match;
    logic [STALL_W-1:0]  w_stall_nxt;
    logic                w_halt_hit;
    logic                w_stall_hit;
    logic                w_to_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_start_ok  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
        // cycles is only zero on the first RUN cycle, which must never count as a stall
        w_first     = (r_cycles == '0);
        w_match     = !w_first && (bus.pc_in == r_last_pc);
        w_stall_nxt = w_match ? r_stall + 1'b1 : '0;
        w_halt_hit  = bus.halt_addr_en && (bus.pc_in == bus.halt_addr);
        w_stall_hit = w_match && (w_stall_nxt == STALL_LIM);
        w_to_hit    = TO_EN && (r_cycles == CYC_LIM);
        w_next      = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_next = S_HOLD;
            S_HOLD:         if (r_hold == '0) w_next = S_RUN;
            S_RUN:          if (w_halt_hit || w_stall_hit || w_to_hit) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_stall    <= '0;
            r_cycles   <= '0;
            r_last_pc  <= '0;
            r_core_rst <= 1'b1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_core_rst <= (w_next != S_RUN);
            r_running  <= (w_next == S_RUN);
            r_done     <= (w_next == S_DONE);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_hold    <= HOLD_LOAD;
                        r_stall   <= '0;
                        r_cycles  <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_hold != '0) r_hold <= r_hold - 1'b1;
                end
                S_RUN: begin
                    r_cycles  <= sat_inc(r_cycles);
                    r_last_pc <= bus.pc_in;
                    r_stall   <= w_stall_nxt;
                    // budget expiry only names the cause when no higher-priority exit fired
                    r_timeout <= w_to_hit && !w_halt_hit && !w_stall_hit;
                end
                default: ;
            endcase
        end
    end

    assign bus.core_rst = r_core_rst;
    assign bus.running  = r_running;
    assign bus.done     = r_done;
    assign bus.timeout  = r_timeout;
    assign bus.cycles   = r_cycles;
    assign bus.last_pc  = r_last_pc;

`ifdef MM_RUN_TRACE_EN
    localparam int TI_W = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0]  r_trace [TRACE_DEPTH];
    logic [TI_W-1:0]  r_wptr;
    logic [TI_W:0]    r_vcnt;
    logic [TI_W-1:0]  w_rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_vcnt <= '0;
        end else if (w_start_ok) begin
            r_wptr <= '0;
            r_vcnt <= '0;
        end else if (r_state == S_RUN) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_vcnt != (TI_W+1)'(TRACE_DEPTH)) r_vcnt <= r_vcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RUN) r_trace[r_wptr] <= bus.pc_in;
    end

    // newest entry sits one slot behind the write pointer
    always_comb begin
        w_rptr       = r_wptr - TI_W'(1) - bus.trace_idx;
        bus.trace_pc = ({1'b0, bus.trace_idx} < r_vcnt) ? r_trace[w_rptr] : '0;
    end
`endif
endmodule

// File: tb/tb_mm2017_run_ctrl.sv
// Scoreboard bench for mm2017_run_ctrl: directed runs plus randomized PC streams.
// Trace checks compile in when MM_RUN_TRACE_EN is defined.
module tb_mm2017_run_ctrl;
    localparam int PC_W        = 32;
    localparam int CNT_W       = 16;
    localparam int RST_HOLD    = 4;
    localparam int HALT_STABLE = 8;
    localparam int MAX_CYCLES  = 20;
    localparam int TRACE_DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm2017_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)) bus ();

    mm2017_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .HALT_STABLE(HALT_STABLE),
        .MAX_CYCLES(MAX_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic             to;
        logic [CNT_W-1:0] cyc;
        logic [PC_W-1:0]  lpc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad   = 0;
    logic [PC_W-1:0] pcs [64];
    int              ridx  = 0;
    logic            prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the PC stream and apply the exit rules in priority order.
    function automatic exp_t model(input logic [PC_W-1:0] ha, input logic en);
        exp_t e;
        e = '0;
        for (int k = 0; k < 64; k++) begin
            int run;
            run = 1;
            for (int j = k; j > 0 && pcs[j-1] == pcs[k]; j--) run++;
            e.cyc = CNT_W'(k + 1);
            e.lpc = pcs[k];
            if (en && pcs[k] == ha) begin e.to = 1'b0; return e; end
            if (run >= HALT_STABLE) begin e.to = 1'b0; return e; end
            if (MAX_CYCLES != 0 && k + 1 == MAX_CYCLES) begin e.to = 1'b1; return e; end
        end
        return e;
    endfunction

    // Core stand-in: presents the next PC of the stream while the controller runs it.
    always @(negedge clk) begin
        if (bus.running && ridx < 64) begin
            bus.pc_in = pcs[ridx];
            ridx = ridx + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("core_rst_vs_running", {63'd0, bus.core_rst}, {63'd0, ~bus.running});
            if (bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("timeout", {63'd0, bus.timeout}, {63'd0, e.to});
                    check("cycles", 64'(bus.cycles), 64'(e.cyc));
                    check("last_pc", 64'(bus.last_pc), 64'(e.lpc));
                end
            end
        end
        prev_done = bus.done;
    end

    task automatic do_start(input logic [PC_W-1:0] ha, input logic en);
        int n;
        @(negedge clk);
        bus.halt_addr    = ha;
        bus.halt_addr_en = en;
        bus.start        = 1'b1;
        ridx             = 0;
        sb.push_back(model(ha, en));
        @(negedge clk);
        bus.start = 1'b0;
        check("start_clears_cycles", 64'(bus.cycles), 64'd0);
        check("start_clears_done", {63'd0, bus.done}, 64'd0);
`ifdef MM_RUN_TRACE_EN
        bus.trace_idx = '0;
        #1 check("trace_empty_after_start", 64'(bus.trace_pc), 64'd0);
`endif
        n = 0;
        while (!bus.running && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_len", 64'(n), 64'(RST_HOLD));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {63'd0, bus.done}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.halt_addr    = '0;
        bus.halt_addr_en = 1'b0;
        bus.pc_in        = '0;
`ifdef MM_RUN_TRACE_EN
        bus.trace_idx    = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        repeat (10) @(negedge clk);
        check("idle_core_rst", {63'd0, bus.core_rst}, 64'd1);
        check("idle_running", {63'd0, bus.running}, 64'd0);
        check("idle_done", {63'd0, bus.done}, 64'd0);
        check("idle_cycles", 64'(bus.cycles), 64'd0);

        // halt address match
        for (int k = 0; k < 64; k++) pcs[k] = PC_W'(4 * k);
        do_start(PC_W'('h40), 1'b1);
        wait_done();
        check("t2_cycles", 64'(bus.cycles), 64'd17);
        check("t2_last_pc", 64'(bus.last_pc), 64'h40);
        check("t2_timeout", {63'd0, bus.timeout}, 64'd0);
        repeat (3) @(negedge clk);
        check("t2_done_sticky", {63'd0, bus.done}, 64'd1);
        check("t2_cycles_held", 64'(bus.cycles), 64'd17);

        // PC stall
        pcs[0] = 0; pcs[1] = 4;
        for (int k = 2; k < 64; k++) pcs[k] = 8;
        do_start('0, 1'b0);
        wait_done();
        check("t3_cycles", 64'(bus.cycles), 64'd10);
        check("t3_last_pc", 64'(bus.last_pc), 64'd8);
        check("t3_timeout", {63'd0, bus.timeout}, 64'd0);

        // budget expiry
        for (int k = 0; k < 64; k++) pcs[k] = PC_W'(4 * k);
        do_start('0, 1'b0);
        wait_done();
        check("t4_cycles", 64'(bus.cycles), 64'd20);
        check("t4_timeout", {63'd0, bus.timeout}, 64'd1);
`ifdef MM_RUN_TRACE_EN
        bus.trace_idx = 4'd0;
        #1 check("trace_newest", 64'(bus.trace_pc), 64'h4C);
        bus.trace_idx = 4'd15;
        #1 check("trace_oldest", 64'(bus.trace_pc), 64'h10);
        bus.trace_idx = 4'd0;
`endif

        // halt on the last budget cycle wins; start while running is ignored
        do_start(PC_W'(4 * (MAX_CYCLES - 1)), 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check("t5_cycles", 64'(bus.cycles), 64'd20);
        check("t5_timeout", {63'd0, bus.timeout}, 64'd0);
        do_start(PC_W'('h40), 1'b1);
        wait_done();
        check("t5_restart_cycles", 64'(bus.cycles), 64'd17);

        // randomized PC streams
        for (int r = 0; r < 30; r++) begin
            int stick;
            stick = $urandom_range(1, 30);
            for (int k = 0; k < 64; k++) begin
                if (k >= stick) pcs[k] = pcs[k-1];
                else            pcs[k] = PC_W'($urandom_range(0, 31) * 4);
            end
            do_start(PC_W'($urandom_range(0, 31) * 4), 1'($urandom_range(0, 1)));
            wait_done();
        end

        // asynchronous reset during RUN
        for (int k = 0; k < 64; k++) pcs[k] = PC_W'(4 * k);
        do_start('0, 1'b0);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_core_rst", {63'd0, bus.core_rst}, 64'd1);
        check("arst_running", {63'd0, bus.running}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_cycles", 64'(bus.cycles), 64'd0);
        check("arst_last_pc", 64'(bus.last_pc), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", {63'd0, bus.core_rst}, 64'd1);
        check("post_rst_done", {63'd0, bus.done}, 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
